// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Provides the word/register-select types, arbiter state codes, requester
// index constants and a helper that sizes index fields.
package regfile_wb_arbiter_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    // One register-file write beat.
    typedef struct packed {
        regbits_t wsel;
        word_t    wdata;
    } wb_beat_t;

    // Arbiter state codes.
    typedef logic [0:0] wb_arb_state_t;
    localparam wb_arb_state_t WBA_IDLE   = 1'b0;
    localparam wb_arb_state_t WBA_LOCKED = 1'b1;

    // Requester count and indices.
    localparam int unsigned WB_NREQ = 3;
    localparam int unsigned WB_ALU  = 0;
    localparam int unsigned WB_LSU  = 1;
    localparam int unsigned WB_TC   = 2;

    // Width of an index into n requesters (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle plus the registered register-file write port.
//   req_valid/req_lock/req_wsel/req_wdata : requester -> arbiter
//   req_ready                             : arbiter -> requester (combinational)
//   WEN/wsel/wdata                        : arbiter -> register file (registered)
//   grant_id/locked/lock_abort            : arbiter status (registered)
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = WB_NREQ
) ();

    localparam int unsigned IDW = idx_w(NREQ);

    logic     [NREQ-1:0] req_valid;
    logic     [NREQ-1:0] req_lock;
    regbits_t [NREQ-1:0] req_wsel;
    word_t    [NREQ-1:0] req_wdata;
    logic     [NREQ-1:0] req_ready;
    logic                WEN;
    regbits_t            wsel;
    word_t               wdata;
    logic     [IDW-1:0]  grant_id;
    logic                locked;
    logic                lock_abort;

    // Requester / writeback-stage side.
    modport master (
        output req_valid, req_lock, req_wsel, req_wdata,
        input  req_ready, WEN, wsel, wdata, grant_id, locked, lock_abort
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_lock, req_wsel, req_wdata,
        output req_ready, WEN, wsel, wdata, grant_id, locked, lock_abort
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above start,
// wrapping at NREQ-1 back to 0.
//   req     : request vector
//   start   : index searched first (always < NREQ)
//   grant_c : one-hot grant, zero when no request
//   idx_c   : winner index
//   any_c   : at least one request present
module regfile_wb_arbiter_rr_picker
    import regfile_wb_arbiter_pkg::*;
#(
    parameter  int unsigned NREQ = WB_NREQ,
    localparam int unsigned IDW  = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  start,
    output logic [NREQ-1:0] grant_c,
    output logic [IDW-1:0]  idx_c,
    output logic            any_c
);

    // Walk NREQ positions from start; wrap explicitly since NREQ may not be 2^n.
    always_comb begin : pick
        int unsigned pos;
        pos     = 0;
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = 32'(start) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            if (!any_c && req[IDW'(pos)]) begin
                any_c = 1'b1;
                idx_c = IDW'(pos);
            end
        end
        if (any_c) begin
            grant_c[idx_c] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port, with an
// owner lock for multi-beat bursts and an idle timeout that breaks the lock.
//   CLK, nRST : clock, asynchronous active-low reset
//   bus       : request bundle, registered write port and status
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter  int unsigned NREQ         = WB_NREQ,
    parameter  int unsigned LOCK_TIMEOUT = 16,
    localparam int unsigned IDW          = idx_w(NREQ),
    localparam int unsigned CNT_W        = $clog2(LOCK_TIMEOUT) + 1
) (
    input  logic                 CLK,
    input  logic                 nRST,
    regfile_wb_arbiter_if.slave  bus
);

    wb_arb_state_t    state_q,    state_d;
    logic [IDW-1:0]   rr_ptr_q,   rr_ptr_d;
    logic [IDW-1:0]   owner_q,    owner_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             wen_q,      wen_d;
    wb_beat_t         beat_q,     beat_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic             abort_q,    abort_d;

    logic [NREQ-1:0]  pick_grant_c;
    logic [IDW-1:0]   pick_idx_c;
    logic             pick_any_c;
    logic [NREQ-1:0]  ready_c;
    logic [IDW-1:0]   winner_c;
    logic             accept_c;

    regfile_wb_arbiter_rr_picker #(.NREQ(NREQ)) u_picker (
        .req     (bus.req_valid),
        .start   (rr_ptr_q),
        .grant_c (pick_grant_c),
        .idx_c   (pick_idx_c),
        .any_c   (pick_any_c)
    );

    // Grant selection and next-state logic.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        idle_cnt_d = idle_cnt_q;
        wen_d      = 1'b0;
        beat_d     = beat_q;
        grant_id_d = grant_id_q;
        abort_d    = 1'b0;
        ready_c    = '0;
        winner_c   = pick_idx_c;
        accept_c   = 1'b0;

        // Ready depends only on state, pointer and valid.
        if (state_q == WBA_IDLE) begin
            ready_c  = pick_grant_c;
            accept_c = pick_any_c;
        end else begin
            ready_c[owner_q] = bus.req_valid[owner_q];
            winner_c         = owner_q;
            accept_c         = bus.req_valid[owner_q];
        end

        // Write path: register 0 beats are accepted but never written.
        if (accept_c) begin
            beat_d.wsel  = bus.req_wsel[winner_c];
            beat_d.wdata = bus.req_wdata[winner_c];
            grant_id_d   = winner_c;
            wen_d        = (bus.req_wsel[winner_c] != '0);
        end

        if (state_q == WBA_IDLE) begin
            if (accept_c) begin
                rr_ptr_d = (winner_c == IDW'(NREQ - 1)) ? '0 : winner_c + IDW'(1);
                if (bus.req_lock[winner_c]) begin
                    state_d    = WBA_LOCKED;
                    owner_d    = winner_c;
                    idle_cnt_d = '0;
                end
            end
        end else begin
            if (accept_c) begin
                idle_cnt_d = '0;
                if (!bus.req_lock[owner_q]) begin
                    state_d = WBA_IDLE;
                end
            end else if (idle_cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                // Timeout fires before the counter can wrap.
                state_d = WBA_IDLE;
                abort_d = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + CNT_W'(1);
            end
        end
    end

    // State and write-port registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= WBA_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            idle_cnt_q <= '0;
            wen_q      <= 1'b0;
            beat_q     <= '0;
            grant_id_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            idle_cnt_q <= idle_cnt_d;
            wen_q      <= wen_d;
            beat_q     <= beat_d;
            grant_id_q <= grant_id_d;
            abort_q    <= abort_d;
        end
    end

    assign bus.req_ready  = ready_c;
    assign bus.WEN        = wen_q;
    assign bus.wsel       = beat_q.wsel;
    assign bus.wdata      = beat_q.wdata;
    assign bus.grant_id   = grant_id_q;
    assign bus.locked     = (state_q == WBA_LOCKED);
    assign bus.lock_abort = abort_q;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port (WEN, wsel, wdata) among NREQ writeback requesters: scalar ALU, load unit and tensor-core result drain. Arbitration is round-robin per cycle, with an optional lock that lets one requester, typically the tensor drain, hold the port for a multi-beat burst. The write port is registered: an accepted beat appears on WEN/wsel/wdata exactly one cycle later. The block sits between the writeback stage and the rf modport of the register file interface.

## Interface
- NREQ, 3: number of requesters, 2..8.
- LOCK_TIMEOUT, 16: idle cycles a locked owner may leave valid low before the lock is forcibly released.
- CLK  in  1  clock; all state is on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  requester i has a write pending.
- req_lock  in  NREQ  requester i asks to keep the port after this beat.
- req_wsel  in  NREQ x regbits_t  destination register per requester.
- req_wdata  in  NREQ x word_t  write data per requester.
- req_ready  out  NREQ  one-hot or zero; the beat of requester i is accepted when req_valid[i] && req_ready[i].
- WEN  out  1  register-file write enable, registered.
- wsel  out  regbits_t  register-file write select, registered.
- wdata  out  word_t  register-file write data, registered.
- grant_id  out  clog2(NREQ)  index of the last accepted requester, registered.
- locked  out  1  high while in state LOCKED.
- lock_abort  out  1  one-cycle pulse when the timeout forces a lock release.

## Operation
- **States**
  - IDLE: no owner; round-robin arbitration.
  - LOCKED: only the owner may be granted.
- **IDLE arbitration**
  - Search starts at rr_ptr and proceeds upward with wrap.
  - The first i with req_valid[i] set gets req_ready[i]=1.
  - On accept, rr_ptr becomes (winner+1) mod NREQ.
  - If the accepted beat has req_lock=1: owner <= winner, state becomes LOCKED, idle_cnt <= 0.
- **LOCKED**
  - req_ready[owner] = req_valid[owner]; every other ready bit is 0.
  - An accepted beat with req_lock=0 is the final beat: state returns to IDLE in the next cycle. rr_ptr = owner+1 was already set at lock entry and is unchanged.
  - Each cycle with owner valid low increments idle_cnt; an owner accept clears it.
  - When idle_cnt reaches LOCK_TIMEOUT-1 while valid is still low: go to IDLE and pulse lock_abort in the following cycle.
- **Write path**
  - On any accept: wsel/wdata/grant_id <= the winner's values; WEN <= 1 unless the winner's wsel == 0.
  - Register 0 is hardwired, so its writes are accepted and dropped.
  - With no accept, WEN <= 0; wsel, wdata and grant_id hold.
- req_ready is combinational from the current state, rr_ptr and req_valid. It must not depend on req_wsel, req_wdata or req_lock.
- NREQ is not a power of two: rr_ptr wraps at NREQ-1 to 0, never through unused codes.

## Timing
- **Reset values:** state IDLE, rr_ptr 0, owner 0, idle_cnt 0, WEN 0, wsel 0, wdata 0, grant_id 0, locked 0, lock_abort 0. req_ready follows arbitration on the reset state.
- **Latency:** accept in cycle t gives WEN/wsel/wdata valid in cycle t+1. Throughput is one write per cycle.
- **Handshake:** a requester holds valid, lock, wsel and wdata stable until accepted. Dropping valid before accept is legal only outside an owned lock.
- **Simultaneous events**
  - Final beat (lock=0) and another requester's valid in the same cycle: only the owner is granted in that cycle. The other requester can be granted from the next cycle.
  - Timeout cycle: no grant is given. The lock_abort pulse and IDLE arbitration coincide in the next cycle.
- **Reset mid-burst:** asynchronous clear to the reset values. Any beat already registered is lost, WEN drops immediately, and the lock is gone.
- The counter saturates; no wrap is possible because the timeout fires at LOCK_TIMEOUT-1.

## Structure
- **datapath_pkg additions:**
  - typedef enum logic {WBA_IDLE, WBA_LOCKED} wb_arb_state_t.
  - Constant WB_NREQ=3.
  - Requester index constants WB_ALU=0, WB_LSU=1, WB_TC=2.
- regbits_t and word_t come from the existing isa_pkg/datapath_pkg types.
- **Sub-module rr_picker:** purely combinational.
  - Inputs: NREQ-bit request vector and start pointer.
  - Outputs: one-hot grant and winner index.
  - Reused for the read-port scheduler.

## Test plan
- After reset, all valid=0: WEN=0, req_ready=000, grant_id=0, locked=0.
- Requesters 0, 1 and 2 all valid with lock=0, wsel 1/2/3, data A/B/C for three cycles: accepts go 0,1,2. WEN is high on cycles 1..3 with wsel 1,2,3 and data A,B,C.
- Requester 2 sends a 4-beat burst with lock=1,1,1,0 while requester 0 is continuously valid: requester 0 is blocked until the cycle after the final beat, then granted. locked is high for exactly 3 cycles.
- Requester 1 takes the lock, then drops valid for 16 cycles: on the 16th idle cycle there is no grant. Next cycle lock_abort=1, locked=0, and requester 0 is granted if valid.
- A write to wsel=0 with data 0xDEADBEEF: req_ready=1, and WEN stays 0 in the next cycle.
- nRST pulled low mid-burst between clock edges: WEN, locked and state clear immediately. After release, arbitration starts at rr_ptr 0.
